// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage pipeline: load-use interlock, taken-branch
// flush, multi-cycle data-memory wait with watchdog, and saturating statistics.
module pipeline_hazard_ctrl #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memread,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_write,
   output logic             idex_bubble,
   output logic             exmem_write,
   output logic             memwb_bubble,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StRun, StMemWait, StTimeout} state_e;

   state_e             state_q, state_d;
   logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

   logic lu, mw, full_hold, eval_run;

   // Next-state logic and pipeline register controls.
   always_comb begin
      lu = ex_memread && (ex_rd != 5'd0) &&
           ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
      mw = mem_req && !mem_ready;

      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      full_hold    = 1'b0;
      eval_run     = 1'b0;
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_write   = 1'b1;
      idex_bubble  = 1'b0;
      exmem_write  = 1'b1;
      memwb_bubble = 1'b0;

      unique case (state_q)
         StRun: begin
            if (mw) begin
               full_hold  = 1'b1;
               state_d    = StMemWait;
               wait_cnt_d = WaitW'(1);
            end else begin
               eval_run = 1'b1;
            end
         end
         StMemWait: begin
            if (!mem_ready) begin
               full_hold = 1'b1;
               // The counter already includes this cycle's wait once incremented.
               if (wait_cnt_q >= WaitW'(TIMEOUT - 1)) begin
                  state_d = StTimeout;
               end else begin
                  wait_cnt_d = wait_cnt_q + WaitW'(1);
               end
            end else begin
               // Release cycle: a branch held in EX during the wait is honoured now.
               eval_run = 1'b1;
               state_d  = StRun;
            end
         end
         StTimeout: full_hold = 1'b1;
         default:   state_d   = StRun;
      endcase

      if (full_hold) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_write   = 1'b0;
         exmem_write  = 1'b0;
         memwb_bubble = 1'b1;
      end else if (eval_run) begin
         if (ex_branch_taken) begin
            // ID holds a wrong-path instruction, so any load-use match is moot.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end else if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
         end
      end

      mem_timeout = (state_q == StTimeout);
   end

   // Saturating statistics counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (ifid_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StRun;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: the driver queues hand-computed
// expectations per cycle; a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned CNT_W = 4;
   // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write,
   //  memwb_bubble, mem_timeout}
   localparam logic [7:0] RUNOK = 8'hD4;
   localparam logic [7:0] LU    = 8'h1C;
   localparam logic [7:0] BR    = 8'hFC;
   localparam logic [7:0] HOLD  = 8'h02;
   localparam logic [7:0] TO    = 8'h03;

   logic             clk, rst_n;
   logic [4:0]       id_rs1, id_rs2, ex_rd;
   logic             id_uses_rs1, id_uses_rs2, ex_memread, ex_branch_taken;
   logic             mem_req, mem_ready;
   logic             pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
   logic             exmem_write, memwb_bubble, mem_timeout;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   typedef struct {
      logic [7:0] ctl;
      logic [3:0] stall;
      logic [3:0] flush;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_uses_rs1     (id_uses_rs1),
      .id_uses_rs2     (id_uses_rs2),
      .ex_rd           (ex_rd),
      .ex_memread      (ex_memread),
      .ex_branch_taken (ex_branch_taken),
      .mem_req         (mem_req),
      .mem_ready       (mem_ready),
      .pc_write        (pc_write),
      .ifid_write      (ifid_write),
      .ifid_flush      (ifid_flush),
      .idex_write      (idex_write),
      .idex_bubble     (idex_bubble),
      .exmem_write     (exmem_write),
      .memwb_bubble    (memwb_bubble),
      .mem_timeout     (mem_timeout),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: compare the combinational outputs and counters mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t       e;
         logic [7:0] ctl;
         e   = exp_q.pop_front();
         ctl = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write,
                memwb_bubble, mem_timeout};
         total++;
         if (ctl !== e.ctl || stall_cnt !== e.stall || flush_cnt !== e.flush) begin
            bad++;
            $display("FAIL %s: got ctl=%b stall=%0d flush=%0d, want ctl=%b stall=%0d flush=%0d",
                     e.name, ctl, stall_cnt, flush_cnt, e.ctl, e.stall, e.flush);
         end
      end
   end

   task automatic push(input logic [7:0] ctl, input int s, input int f, input string name);
      exp_t e;
      e.ctl   = ctl;
      e.stall = 4'(s);
      e.flush = 4'(f);
      e.name  = name;
      exp_q.push_back(e);
   endtask

   task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic [4:0] erd, input logic mr, input logic br,
                       input logic req, input logic rdy, input logic [7:0] ctl,
                       input int s, input int f, input string name);
      @(posedge clk);
      #1;
      id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
      ex_rd = erd; ex_memread = mr; ex_branch_taken = br;
      mem_req = req; mem_ready = rdy;
      push(ctl, s, f, name);
   endtask

   task automatic idle(input logic [7:0] ctl, input int s, input int f, input string name);
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ctl, s, f, name);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_rd = '0; ex_memread = 1'b0; ex_branch_taken = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      idle(RUNOK, 0, 0, "reset_idle");
      // Load-use on rs2, then the load advances.
      step(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU, 0, 0, "lu_rs2");
      idle(RUNOK, 1, 0, "lu_release");
      step(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, RUNOK, 1, 0, "x0_no_lu");
      step(5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, RUNOK, 1, 0, "unused_rs1");
      step(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, LU, 1, 0, "lu_rs1");
      step(5'd0, 5'd5, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, RUNOK, 2, 0, "rd_mismatch");
      step(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, RUNOK, 2, 0, "not_load");

      // Branch beats load-use.
      do_reset();
      step(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, BR, 0, 0, "br_over_lu");
      idle(RUNOK, 0, 1, "after_br");

      // Memory wait, branch flushed on the release cycle.
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, HOLD, 0, 1, "mw_1");
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, HOLD, 1, 1, "mw_2");
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, HOLD, 2, 1, "mw_3_br_held");
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, BR, 3, 1, "mw_release_br");
      idle(RUNOK, 3, 2, "mw_back_run");
      // Load-use evaluated on a release cycle.
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, HOLD, 3, 2, "mw2_hold");
      step(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, LU, 4, 2, "mw2_release_lu");
      idle(RUNOK, 5, 2, "mw2_done");

      // Watchdog: four wait cycles, then sticky error.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, HOLD, k, 0, "to_wait");
      end
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, TO, 4, 0, "to_entered");
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, TO, 5, 0, "to_ready_ignored");
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, TO, 6, 0, "to_br_ignored");
      idle(TO, 7, 0, "to_sticky");
      // Asynchronous clear: checked before any further clock edge.
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0; ex_branch_taken = 1'b0;
      push(RUNOK, 0, 0, "async_rst");
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(RUNOK, 0, 0, "after_async_rst");

      // Stall counter saturation (timeout state stalls every cycle).
      for (int k = 0; k < 20; k++) begin
         step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, (k < 4) ? HOLD : TO,
              (k < 15) ? k : 15, 0, "stall_sat");
      end

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
